spdif_feed_ctrl: RTL
====================

SPDIF_FEED_CTRL -- requirements
Module: spdif_feed_ctrl

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, number of stereo-pair entries buffered (power of 2, 2..16).
REQ-002 Parameter: CS_FS_CODE, default 4'b0000, channel-status sample-rate code (bits 24-27; 0000 = 44.1 kHz).
REQ-003 I_clk  in  1  single clock for all logic.
REQ-004 I_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 I_smp_l, I_smp_r  in  16 each  left/right PCM sample pair from audio source.
REQ-006 I_smp_valid  in  1 / O_smp_ready  out  1  push handshake for the pair.
REQ-007 I_mute  in  1  force zero samples.
REQ-008 I_copy_ok  in  1 / I_category  in  8  channel-status config.
REQ-009 I_clr_stat  in  1  clears underrun statistics.
REQ-010 I_audio_d_req, I_validity_bit_req, I_user_bit_req, I_chan_status_bit_req  in  1 each  request pulses from SPDIF_TX_Top.
REQ-011 I_block_start_flag, I_sub_frame0_flag, I_sub_frame1_flag  in  1 each  frame-position flags from SPDIF_TX_Top.
REQ-012 O_audio_d  out  16 / O_validity_bit, O_user_bit, O_chan_status_bit  out  1 each  data to SPDIF_TX_Top.
REQ-013 O_underrun  out  1  sticky underrun flag / O_underrun_cnt  out  8  saturating underrun count.

Function
REQ-014 FIFO of FIFO_DEPTH entries, 32 bits each {L,R}; O_smp_ready = not full; push on I_smp_valid && O_smp_ready.
REQ-015 Push and pop in the same cycle when not full and not empty: both occur, occupancy unchanged.
REQ-016 Full with simultaneous pop: O_smp_ready low that cycle, no push; ready rises the following cycle.
REQ-017 Left service: I_audio_d_req && I_sub_frame0_flag at a rising edge; if FIFO non-empty, pop, O_audio_d <= L on that edge, R latched into a right-holding register.
REQ-018 Right service: I_audio_d_req && I_sub_frame1_flag; O_audio_d <= right-holding register on that edge; no pop.
REQ-019 Data latency: O_audio_d, O_validity_bit, O_user_bit, O_chan_status_bit update on the same edge the request is sampled and hold until the next request of their type.
REQ-020 Underrun: left service with FIFO empty -> O_audio_d = 0 for both subframes of that frame, frame-underrun bit set, O_underrun set, O_underrun_cnt += 1 saturating at 255.
REQ-021 I_mute high at left service: FIFO still popped if non-empty; both subframes output 0; validity remains 0 unless underrun.
REQ-022 O_validity_bit on validity request = current frame-underrun bit (1 = invalid); O_user_bit always 0.
REQ-023 Frame counter 0..191: set to 0 at left service when I_block_start_flag high, otherwise increment at each left service, wrap 191 -> 0.
REQ-024 I_copy_ok, I_category captured into shadow registers at left service with I_block_start_flag high; never change mid-block.
REQ-025 O_chan_status_bit on chan-status request = CS[frame counter], identical for both subframes: bit2 = copy_ok shadow; bits 8-15 = category shadow (bit8 = LSB); bits 24-27 = CS_FS_CODE (bit24 = LSB); bit33 = 1 (16-bit word length); all other bits 0.
REQ-026 I_clr_stat clears O_underrun and O_underrun_cnt; an underrun on the same edge wins (flag = 1, count = 1).
REQ-027 Requests absent: all outputs hold; requests with neither subframe flag high are ignored.

Reset
REQ-028 I_rst_n low asynchronously clears FIFO pointers/occupancy, right-holding register, frame counter (0), shadows (0), frame-underrun bit, all outputs to 0; O_smp_ready = 0 during reset, 1 the first edge after release.
REQ-029 Reset mid-block: after release, the next left service without I_block_start_flag uses frame index 1; alignment is restored at the next block start.

Verification
REQ-030 Push pairs {0x1234,0xABCD}, {0x0001,0xFFFF}; serve L,R,L,R -> O_audio_d 0x1234, 0xABCD, 0x0001, 0xFFFF; validity 0 each.
REQ-031 Empty FIFO, left service then right service -> O_audio_d 0, 0; validity 1; O_underrun 1; count 1; 300 underruns -> count 255.
REQ-032 Fill to 4 entries, assert I_smp_valid with a same-cycle left service -> no push, occupancy 3 next cycle, ready 1.
REQ-033 I_copy_ok = 1, I_category = 0x82, run 192 frames from block start -> CS bits 2, 9, 15, 33 = 1, all others 0; config change mid-block has no effect until the next block start.
REQ-034 I_mute with full FIFO over 4 frames -> outputs 0, FIFO drains to 0, validity 0.
REQ-035 Assert I_rst_n low mid-frame -> all outputs 0 immediately, FIFO empty, O_smp_ready 0 until the edge after release.

Source files
------------

// File: rtl/spdif_feed_ctrl.sv
// Stereo PCM feeder for an SPDIF transmitter: sample FIFO, subframe data
// service, channel-status generation and underrun statistics.
module spdif_feed_ctrl #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [3:0] CS_FS_CODE = 4'b0000
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic [15:0] I_smp_l,
  input  logic [15:0] I_smp_r,
  input  logic        I_smp_valid,
  output logic        O_smp_ready,
  input  logic        I_mute,
  input  logic        I_copy_ok,
  input  logic [7:0]  I_category,
  input  logic        I_clr_stat,
  input  logic        I_audio_d_req,
  input  logic        I_validity_bit_req,
  input  logic        I_user_bit_req,
  input  logic        I_chan_status_bit_req,
  input  logic        I_block_start_flag,
  input  logic        I_sub_frame0_flag,
  input  logic        I_sub_frame1_flag,
  output logic [15:0] O_audio_d,
  output logic        O_validity_bit,
  output logic        O_user_bit,
  output logic        O_chan_status_bit,
  output logic        O_underrun,
  output logic [7:0]  O_underrun_cnt
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ready_q;
  logic [15:0]   rhold_q, audio_q;
  logic [7:0]    fcnt_q, fcnt_d;
  logic          copy_q, copy_d;
  logic [7:0]    cat_q, cat_d;
  logic          fur_q, fur_d;
  logic          val_q, user_q, cs_q;
  logic          ur_q;
  logic [7:0]    urc_q;

  logic        empty, any_sf, left, right;
  logic        push, pop, ur_ev, cs_bit;
  logic [31:0] head;

  always_comb begin
    empty  = (cnt_q == '0);
    any_sf = I_sub_frame0_flag | I_sub_frame1_flag;
    left   = I_audio_d_req & I_sub_frame0_flag;
    right  = I_audio_d_req & ~I_sub_frame0_flag
           & I_sub_frame1_flag;
    push   = I_smp_valid & ready_q;
    pop    = left & ~empty;
    ur_ev  = left & empty;
    head   = mem_q[rptr_q];
    cnt_d  = cnt_q;
    if (push && !pop)
      cnt_d = cnt_q + CW'(1);
    else if (pop && !push)
      cnt_d = cnt_q - CW'(1);
  end

  // Frame index and shadows resolve first so same-edge requests see them.
  always_comb begin
    fcnt_d = fcnt_q;
    copy_d = copy_q;
    cat_d  = cat_q;
    fur_d  = fur_q;
    if (left) begin
      fur_d = empty;
      if (I_block_start_flag) begin
        fcnt_d = 8'd0;
        copy_d = I_copy_ok;
        cat_d  = I_category;
      end else if (fcnt_q == 8'd191) begin
        fcnt_d = 8'd0;
      end else begin
        fcnt_d = fcnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    cs_bit = 1'b0;
    unique case (1'b1)
      (fcnt_d == 8'd2):
        cs_bit = copy_d;
      (fcnt_d >= 8'd8 && fcnt_d <= 8'd15):
        cs_bit = cat_d[fcnt_d[2:0]];
      (fcnt_d >= 8'd24 && fcnt_d <= 8'd27):
        cs_bit = CS_FS_CODE[fcnt_d[1:0]];
      (fcnt_d == 8'd33):
        cs_bit = 1'b1;
      default: cs_bit = 1'b0;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (push) mem_q[wptr_q] <= {I_smp_l, I_smp_r};
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      rhold_q <= '0;
      audio_q <= '0;
      fcnt_q  <= '0;
      copy_q  <= 1'b0;
      cat_q   <= '0;
      fur_q   <= 1'b0;
      val_q   <= 1'b0;
      user_q  <= 1'b0;
      cs_q    <= 1'b0;
      ur_q    <= 1'b0;
      urc_q   <= '0;
    end else begin
      cnt_q   <= cnt_d;
      ready_q <= (cnt_d != FULL);
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      fcnt_q <= fcnt_d;
      copy_q <= copy_d;
      cat_q  <= cat_d;
      fur_q  <= fur_d;
      if (left) begin
        if (empty || I_mute) begin
          audio_q <= '0;
          rhold_q <= '0;
        end else begin
          audio_q <= head[31:16];
          rhold_q <= head[15:0];
        end
      end else if (right) begin
        audio_q <= rhold_q;
      end
      if (I_validity_bit_req && any_sf)
        val_q <= fur_d;
      if (I_user_bit_req && any_sf)
        user_q <= 1'b0;
      if (I_chan_status_bit_req && any_sf)
        cs_q <= cs_bit;
      // Underrun beats a same-edge clear: count restarts at one.
      if (ur_ev) begin
        ur_q <= 1'b1;
        if (I_clr_stat)
          urc_q <= 8'd1;
        else if (urc_q != 8'hFF)
          urc_q <= urc_q + 8'd1;
      end else if (I_clr_stat) begin
        ur_q  <= 1'b0;
        urc_q <= '0;
      end
    end
  end

  assign O_smp_ready       = ready_q;
  assign O_audio_d         = audio_q;
  assign O_validity_bit    = val_q;
  assign O_user_bit        = user_q;
  assign O_chan_status_bit = cs_q;
  assign O_underrun        = ur_q;
  assign O_underrun_cnt    = urc_q;

endmodule
